// File: rtl/ir_queue.sv
// Instruction register queue: in-order DEPTH-word buffer between fetch and decode.
// Optional same-cycle fetch-to-decode bypass when empty: define IR_QUEUE_BYPASS_EN.
module ir_queue #(
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       OPC_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [OPC_W-1:0]             out_opcode,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned      PTR_W = $clog2(DEPTH);
  localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stored_vld, push, pop;

  assign stored_vld = (cnt_q != '0);
  assign in_ready   = (cnt_q != FULL);
  assign pop        = stored_vld && out_ready;

`ifdef IR_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = !stored_vld && in_valid && !flush;
  assign out_valid = stored_vld || bypass;
  assign out_data  = stored_vld ? mem_q[rd_q] : (bypass ? in_data : NOP_VAL);
  // A bypassed word taken by the decoder never touches storage.
  assign push      = in_valid && in_ready && !(bypass && out_ready);
`else
  assign out_valid = stored_vld;
  assign out_data  = stored_vld ? mem_q[rd_q] : NOP_VAL;
  assign push      = in_valid && in_ready;
`endif

  assign out_opcode = out_data[DATA_W-1 -: OPC_W];
  assign count      = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is data-only; flush and reset leave contents in place.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= in_data;
  end

endmodule

// File: tb/tb_ir_queue.sv
// Randomized and directed bench for ir_queue against a queue-based reference model.
module tb_ir_queue;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int OPC_W  = 4;
  localparam logic [DATA_W-1:0] NOP = 16'h0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [OPC_W-1:0]  out_opcode;
  logic [2:0]        count;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] q [$];

  ir_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_VAL(NOP), .OPC_W(OPC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_opcode(out_opcode), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the queue contents and the current inputs.
  task automatic check_outputs(input string tag);
    logic              ev;
    logic [DATA_W-1:0] ed;
    ev = (q.size() != 0);
    ed = ev ? q[0] : NOP;
`ifdef IR_QUEUE_BYPASS_EN
    if (!ev && in_valid && !flush) begin
      ev = 1'b1;
      ed = in_data;
    end
`endif
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() != DEPTH));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, "_out_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_opcode"}, 32'(out_opcode), 32'(ed[DATA_W-1 -: OPC_W]));
  endtask

  // One clock: drive at negedge, check mid-cycle, then advance the model at the edge.
  task automatic step(input string tag, input logic fl, input logic iv,
                      input logic [DATA_W-1:0] d, input logic ordy);
    bit do_push, do_pop, byp;
    @(negedge clk);
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    #1 check_outputs(tag);
    do_pop  = (q.size() != 0) && ordy;
    do_push = iv && (q.size() != DEPTH);
    byp = 1'b0;
`ifdef IR_QUEUE_BYPASS_EN
    byp = (q.size() == 0) && iv && ordy && !fl;
`endif
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else if (!byp) begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] words [5];
    int pin, pout;
    words = '{16'h1A01, 16'h2B02, 16'h3C03, 16'h4D04, 16'h5E05};

    // Reset held from time 0
    #1;
    chk("rst0_count", 32'(count), 0);
    chk("rst0_in_ready", 32'(in_ready), 1);
    chk("rst0_out_valid", 32'(out_valid), 0);
    chk("rst0_out_data", 32'(out_data), 32'(NOP));
    @(negedge clk); rst = 1'b1;

    // Fill, overfill, drain
    for (int i = 0; i < 5; i++) step("fill", 1'b0, 1'b1, words[i], 1'b0);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_head", 32'(out_data), 32'h1A01);
    for (int i = 0; i < 4; i++) begin
      step("drain", 1'b0, 1'b0, 16'h0, 1'b1);
    end
    chk("drained_valid", 32'(out_valid), 0);
    chk("drained_data", 32'(out_data), 32'(NOP));

    // Streaming with wrap-around
    for (int i = 1; i <= 10; i++) step("wrap", 1'b0, 1'b1, 16'(i), 1'b1);
    step("wrap_tail", 1'b0, 1'b0, 16'h0, 1'b1);
    chk("wrap_empty", 32'(count), 0);

    // Push+pop at full: only the pop lands
    for (int i = 0; i < 4; i++) step("refill", 1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0);
    step("full_pp", 1'b0, 1'b1, 16'h2FFF, 1'b1);
    chk("full_pp_count", 32'(count), 3);
    chk("full_pp_ready", 32'(in_ready), 1);
    step("full_pp_next", 1'b0, 1'b0, 16'h0, 1'b0);
    step("flush_all", 1'b1, 1'b0, 16'h0, 1'b0);

    // Flush beats push and pop
    step("fp_a", 1'b0, 1'b1, 16'h1111, 1'b0);
    step("fp_b", 1'b0, 1'b1, 16'h2222, 1'b0);
    step("fp_flush", 1'b1, 1'b1, 16'h3333, 1'b1);
    chk("fp_count", 32'(count), 0);
    step("fp_push", 1'b0, 1'b1, 16'h7777, 1'b0);
    chk("fp_head", 32'(out_data), 32'h7777);
    chk("fp_opcode", 32'(out_opcode), 32'h7);
    step("fp_pop", 1'b0, 1'b0, 16'h0, 1'b1);

    // Empty queue with word offered and decoder ready
    step("byp", 1'b0, 1'b1, 16'h9ABC, 1'b1);
`ifdef IR_QUEUE_BYPASS_EN
    chk("byp_count", 32'(count), 0);
`else
    chk("byp_count", 32'(count), 1);
    chk("byp_next", 32'(out_data), 32'h9ABC);
`endif
    step("byp_after", 1'b0, 1'b0, 16'h0, 1'b1);

    // Asynchronous reset mid-stream with three words held
    for (int i = 0; i < 3; i++) step("prerst", 1'b0, 1'b1, 16'hC000 + 16'(i), 1'b0);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 32'(NOP));
    chk("rst_in_ready", 32'(in_ready), 1);
    q.delete();
    @(negedge clk); rst = 1'b1;
    step("post_rst", 1'b0, 1'b1, 16'hBEEF, 1'b0);
    chk("post_rst_head", 32'(out_data), 32'hBEEF);

    // Randomized traffic in fill-biased, drain-biased and balanced segments
    for (int seg = 0; seg < 3; seg++) begin
      pin  = (seg == 0) ? 85 : (seg == 1) ? 30 : 60;
      pout = (seg == 0) ? 30 : (seg == 1) ? 85 : 60;
      for (int n = 0; n < 300; n++) begin
        step("rnd", $urandom_range(0, 24) == 0, $urandom_range(0, 99) < pin,
             16'($urandom), $urandom_range(0, 99) < pout);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
